rg_port_sequencer: RTL and testbench

Sequences operand fetch for the two register fields decoded from the instruction register (RG1 = MIDR_out[11:7], RG2 = MIDR_out[6:2]). It reads both operands through the single-ported register file and shares that port with the writeback requester, with bounded arbitration so neither side starves. It sits between the instruction register, register file and writeback stage, and hands the ALU-side latches a pair of operands with a done pulse.

---
 rtl/rg_port_sequencer.sv | 126 ++++++++++++
 tb/tb_rg_port_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rg_port_sequencer.sv
// Fetches the RG1/RG2 operands through a shared single-port register file and arbitrates that port against writeback with a bounded starve count.
// Optional macro RG_BYPASS_EN forwards writes granted after an operand's read straight into op1/op2.
module rg_port_sequencer #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       MIDR_out,
  input  logic              fetch_start,
  output logic              fetch_busy,
  output logic              fetch_done,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ack,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_RD1, S_RD2, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] a1_q, a1_d, a2_q, a2_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              pend1_q, pend1_d, pend2_q, pend2_d;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
  logic              done_q, done_d;
  logic              read_want, wr_grant, rd_issue;
  logic [ADDR_W-1:0] rf_addr_c;
  logic              unused_midr;

  assign unused_midr = ^{MIDR_out[15:12], MIDR_out[1:0]};

  always_comb begin
    state_d  = state_q;
    a1_d     = a1_q;
    a2_d     = a2_q;
    done_d   = 1'b0;
    op1_d    = op1_q;
    op2_d    = op2_q;

    read_want = (state_q == S_RD1) || (state_q == S_RD2);
    wr_grant  = wb_req && (!read_want || (starve_q < SMAX));
    rd_issue  = read_want && !wr_grant;

    rf_addr_c = '0;
    if (wr_grant)                rf_addr_c = wb_addr;
    else if (state_q == S_RD1)   rf_addr_c = a1_q;
    else if (state_q == S_RD2)   rf_addr_c = a2_q;

    // Only consecutive write wins against a waiting read count towards starvation.
    starve_d = (read_want && wr_grant) ? starve_q + 1'b1 : '0;
    pend1_d  = rd_issue && (state_q == S_RD1);
    pend2_d  = rd_issue && (state_q == S_RD2);

    if (pend1_q) op1_d = rf_rdata;
    if (pend2_q) op2_d = rf_rdata;
`ifdef RG_BYPASS_EN
    // Write data overrides a same-cycle capture so the newest value survives.
    if (wr_grant && (wb_addr == a1_q) && ((state_q == S_RD2) || (state_q == S_WAIT)))
      op1_d = wb_data;
    if (wr_grant && (wb_addr == a2_q) && (state_q == S_WAIT))
      op2_d = wb_data;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (fetch_start) begin
          a1_d    = ADDR_W'(MIDR_out[11:7]);
          a2_d    = ADDR_W'(MIDR_out[6:2]);
          state_d = S_RD1;
        end
      end
      S_RD1:  if (rd_issue) state_d = S_RD2;
      S_RD2:  if (rd_issue) state_d = S_WAIT;
      S_WAIT: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a1_q     <= '0;
      a2_q     <= '0;
      starve_q <= '0;
      pend1_q  <= 1'b0;
      pend2_q  <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a1_q     <= a1_d;
      a2_q     <= a2_d;
      starve_q <= starve_d;
      pend1_q  <= pend1_d;
      pend2_q  <= pend2_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      done_q   <= done_d;
    end
  end

  assign fetch_busy = (state_q != S_IDLE);
  assign fetch_done = done_q;
  assign op1        = op1_q;
  assign op2        = op2_q;
  assign wb_ack     = wr_grant;
  assign rf_we      = wr_grant;
  assign rf_addr    = rf_addr_c;
  assign rf_wdata   = wb_data;

endmodule

// File: tb/tb_rg_port_sequencer.sv
// Bench for rg_port_sequencer: register file model, queued writeback requester and a transaction-level
// latency/operand model (write grants split as min(W,S) before each read). Honours RG_BYPASS_EN.
module tb_rg_port_sequencer;
  localparam int S = 4;

  logic        clk, reset_n, fetch_start, wb_req, wb_ack, rf_we, fetch_busy, fetch_done;
  logic [15:0] MIDR_out, op1, op2, wb_data, rf_wdata, rf_rdata;
  logic [4:0]  wb_addr, rf_addr;

  int ntests = 0;
  int nfail  = 0;

  logic [15:0] rf_mem [32];
  logic [15:0] shadow [32];
  logic [4:0]  wq_addr[$];
  logic [15:0] wq_data[$];

  rg_port_sequencer #(.DATA_W(16), .ADDR_W(5), .STARVE_MAX(S)) dut (
    .clk(clk), .reset_n(reset_n), .MIDR_out(MIDR_out), .fetch_start(fetch_start),
    .fetch_busy(fetch_busy), .fetch_done(fetch_done), .op1(op1), .op2(op2),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ack(wb_ack),
    .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous register file
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_addr] <= rf_wdata;
    rf_rdata <= rf_mem[rf_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] val_after(input logic [4:0] a, input int n);
    logic [15:0] v;
    v = shadow[a];
    for (int k = 0; k < n; k++)
      if (wq_addr[k] == a) v = wq_data[k];
    return v;
  endfunction

  task automatic idle_write(input logic [4:0] a, input logic [15:0] d);
    wb_req = 1'b1; wb_addr = a; wb_data = d;
    #1;
    chk("idle_wb_ack", {31'd0, wb_ack}, 32'd1);
    @(posedge clk); #1;
    wb_req = 1'b0;
    shadow[a] = d;
  endtask

  task automatic run_fetch(input logic [15:0] midr, input bit ign, input logic [15:0] alt);
    logic [4:0]  a1, a2;
    logic [4:0]  rd_a[2];
    logic [15:0] e1, e2;
    int w, g1, g2, nb, exp_done, exp_acks, idx, nrd, done_c;
    bit acked;
    a1 = midr[11:7];
    a2 = midr[6:2];
    w  = wq_addr.size();
    g1 = (w < S) ? w : S;
    g2 = ((w - g1) < S) ? (w - g1) : S;
    exp_done = 4 + g1 + g2;
    nb       = g1 + g2 + ((w > g1 + g2) ? 1 : 0);
    exp_acks = (w < g1 + g2 + 2) ? w : g1 + g2 + 2;
`ifdef RG_BYPASS_EN
    e1 = val_after(a1, nb);
    e2 = val_after(a2, nb);
`else
    e1 = val_after(a1, g1);
    e2 = val_after(a2, g1 + g2);
    if (nb < 0) e1 = 16'h0;
`endif
    rd_a[0] = 5'd0; rd_a[1] = 5'd0;
    idx = 0; nrd = 0; done_c = -1;

    fetch_start = 1'b1; MIDR_out = midr; wb_req = 1'b0;
    @(posedge clk); #1;
    for (int c = 1; c <= 60; c++) begin
      fetch_start = (ign && c == 1);
      if (ign && c == 1) MIDR_out = alt;
      wb_req = (idx < w);
      if (idx < w) begin wb_addr = wq_addr[idx]; wb_data = wq_data[idx]; end
      #1;
      acked = wb_ack;
      if (fetch_busy && !rf_we && nrd < 2) begin rd_a[nrd] = rf_addr; nrd++; end
      if (fetch_done) begin
        done_c = c;
        chk("busy_at_done", {31'd0, fetch_busy}, 32'd0);
      end
      @(posedge clk); #1;
      if (acked) idx++;
      if (done_c >= 0) break;
    end
    wb_req = 1'b0; fetch_start = 1'b0;

    chk("done_cycle", done_c, exp_done);
    chk("op1", {16'd0, op1}, {16'd0, e1});
    chk("op2", {16'd0, op2}, {16'd0, e2});
    chk("ack_count", idx, exp_acks);
    chk("rd_count", nrd, 2);
    chk("rd_addr_a1", {27'd0, rd_a[0]}, {27'd0, a1});
    chk("rd_addr_a2", {27'd0, rd_a[1]}, {27'd0, a2});
    for (int k = 0; k < exp_acks; k++) shadow[wq_addr[k]] = wq_data[k];
    chk("rf_a1", {16'd0, rf_mem[a1]}, {16'd0, shadow[a1]});
    chk("rf_a2", {16'd0, rf_mem[a2]}, {16'd0, shadow[a2]});
    chk("done_pulse_end", {31'd0, fetch_done}, 32'd0);
    chk("busy_after", {31'd0, fetch_busy}, 32'd0);
    wq_addr.delete(); wq_data.delete();
  endtask

  initial begin
    int dones;
    logic [15:0] m;
    logic [4:0]  ra1, ra2;
    reset_n = 1'b0; MIDR_out = '0; fetch_start = 1'b0;
    wb_req = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, fetch_busy}, 32'd0);
    chk("rst_done", {31'd0, fetch_done}, 32'd0);
    chk("rst_op1", {16'd0, op1}, 32'd0);
    chk("rst_op2", {16'd0, op2}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Plain fetch
    idle_write(5'd21, 16'h1234);
    idle_write(5'd2, 16'hBEEF);
    run_fetch(16'h0A88, 1'b0, 16'h0);

    // Write preemption: two writes from cycle 1
    wq_addr.push_back(5'd7); wq_data.push_back(16'h0007);
    wq_addr.push_back(5'd9); wq_data.push_back(16'h0009);
    run_fetch(16'h0A88, 1'b0, 16'h0);

    // Starvation bound: requester never idles during the fetch
    for (int k = 0; k < 12; k++) begin
      wq_addr.push_back(5'(10 + k)); wq_data.push_back(16'(16'hA000 + k));
    end
    run_fetch(16'h0A88, 1'b0, 16'h0);

    // Write to a1 lands in RD2
    for (int k = 0; k < S; k++) begin
      wq_addr.push_back(5'd3); wq_data.push_back(16'(k));
    end
    wq_addr.push_back(5'd21); wq_data.push_back(16'h5555);
    run_fetch(16'h0A88, 1'b0, 16'h0);

    // Ignored start during RD1
    idle_write(5'd21, 16'h1234);
    run_fetch(16'h0A88, 1'b1, 16'hFFFF);

    // Reset in RD2
    fetch_start = 1'b1; MIDR_out = 16'h0A88;
    @(posedge clk); #1;
    fetch_start = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", {31'd0, fetch_busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, fetch_busy}, 32'd0);
    chk("mid_rst_op1", {16'd0, op1}, 32'd0);
    chk("mid_rst_op2", {16'd0, op2}, 32'd0);
    chk("mid_rst_rf_addr", {27'd0, rf_addr}, 32'd0);
    @(posedge clk); #3;
    reset_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (fetch_done) dones++;
    end
    chk("mid_rst_no_done", dones, 0);
    chk("mid_rst_idle", {31'd0, fetch_busy}, 32'd0);

    // Randomised fetches with mixed writeback traffic
    for (int it = 0; it < 25; it++) begin
      m   = 16'($urandom);
      ra1 = m[11:7];
      ra2 = m[6:2];
      idle_write(ra1, 16'($urandom));
      idle_write(ra2, 16'($urandom));
      for (int k = 0; k < int'($urandom_range(0, 11)); k++) begin
        case ($urandom_range(0, 2))
          0:       wq_addr.push_back(ra1);
          1:       wq_addr.push_back(ra2);
          default: wq_addr.push_back(5'($urandom));
        endcase
        wq_data.push_back(16'($urandom));
      end
      run_fetch(m, 1'($urandom_range(0, 1)), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
